// File: rtl/upload_pkg.sv
// Shared constants and state encoding for the upload frame packer.
// Frame layout: HDR0 HDR1 source len_hi len_lo payload... checksum.
package upload_pkg;

  localparam logic [7:0] HDR0_BYTE = 8'hAA;
  localparam logic [7:0] HDR1_BYTE = 8'h44;

  localparam logic [7:0] SRC_UART = 8'h01;
  localparam logic [7:0] SRC_I2C  = 8'h02;
  localparam logic [7:0] SRC_SPI  = 8'h03;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HDR0,
    ST_HDR1,
    ST_SRC,
    ST_LENH,
    ST_LENL,
    ST_PAYLOAD,
    ST_CSUM
  } upload_state_e;

endpackage

// File: rtl/upload_buf_ram.sv
// Simple dual-port byte buffer: synchronous write, registered read.
// rd_data holds its value until the next rd_en, so a stalled consumer sees stable data.
module upload_buf_ram #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/upload_frame_packer.sv
// Buffers one upload burst from a command handler and re-emits it as a framed,
// checksummed packet. Handshakes: a byte moves on upload_valid (ready is advisory,
// one byte of skid is absorbed); tx bytes move on tx_valid && tx_ready, tx_data held otherwise.
module upload_frame_packer
  import upload_pkg::*;
#(
  parameter int          BUF_DEPTH = 256,
  parameter logic [7:0]  HDR0      = HDR0_BYTE,
  parameter logic [7:0]  HDR1      = HDR1_BYTE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upload_req,
  input  logic [7:0]    upload_data,
  input  logic [7:0]    upload_source,
  input  logic          upload_valid,
  output logic          upload_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          drop_pulse,
  output upload_state_e state_dbg
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] READY_MAX = CW'(BUF_DEPTH - 2);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  upload_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    src_q, src_d;
  logic          src_lat_q, src_lat_d;
  logic          upload_ready_q, upload_ready_d;

  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [15:0]   len16;
  logic [7:0]    frame_sum;
  logic          can_store;

  upload_buf_ram #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (upload_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign len16     = 16'(count_q);
  // csum_q carries only the payload sum; the length-dependent terms are folded in at the end.
  assign frame_sum = csum_q + src_q + len16[15:8] + len16[7:0];
  assign can_store = (state_q == ST_COLLECT) && (count_q < DEPTH_C);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_idx_d  = rd_idx_q;
    csum_d    = csum_q;
    src_d     = src_q;
    src_lat_d = src_lat_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (upload_req) begin
          state_d   = ST_COLLECT;
          count_d   = '0;
          csum_d    = 8'h00;
          src_lat_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (upload_valid && can_store) begin
          wr_en   = 1'b1;
          count_d = count_q + ONE_C;
          csum_d  = csum_q + upload_data;
          if (!src_lat_q) begin
            src_d     = upload_source;
            src_lat_d = 1'b1;
          end
        end
        if (count_d == DEPTH_C) state_d = ST_HDR0;
        else if (!upload_req) state_d = (count_d != '0) ? ST_HDR0 : ST_IDLE;
      end
      ST_HDR0: begin
        tx_valid = 1'b1;
        tx_data  = HDR0;
        if (tx_ready) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = HDR1;
        if (tx_ready) state_d = ST_SRC;
      end
      ST_SRC: begin
        tx_valid = 1'b1;
        tx_data  = src_q;
        if (tx_ready) state_d = ST_LENH;
      end
      ST_LENH: begin
        tx_valid = 1'b1;
        tx_data  = len16[15:8];
        if (tx_ready) state_d = ST_LENL;
      end
      ST_LENL: begin
        tx_valid = 1'b1;
        tx_data  = len16[7:0];
        // Prefetch payload[0] so it is on rd_data when PAYLOAD starts.
        if (tx_ready) begin
          state_d  = ST_PAYLOAD;
          rd_en    = 1'b1;
          rd_idx_d = '0;
        end
      end
      ST_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = rd_data;
        if (tx_ready) begin
          if (rd_idx_q == count_q - ONE_C) begin
            state_d = ST_CSUM;
          end else begin
            rd_idx_d = rd_idx_q + ONE_C;
            rd_en    = 1'b1;
            rd_addr  = rd_idx_d[AW-1:0];
          end
        end
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = frame_sum;
        // A full-buffer close keeps the latched source for the continuation frame.
        if (tx_ready) begin
          count_d = '0;
          csum_d  = 8'h00;
          state_d = upload_req ? ST_COLLECT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    upload_ready_d = (state_d == ST_COLLECT) && (count_d <= READY_MAX);
  end

  assign drop_pulse   = upload_valid && !can_store;
  assign upload_ready = upload_ready_q;
  assign state_dbg    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      rd_idx_q       <= '0;
      csum_q         <= 8'h00;
      src_q          <= 8'h00;
      src_lat_q      <= 1'b0;
      upload_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rd_idx_q       <= rd_idx_d;
      csum_q         <= csum_d;
      src_q          <= src_d;
      src_lat_q      <= src_lat_d;
      upload_ready_q <= upload_ready_d;
    end
  end

endmodule

// File: tb/tb_upload_frame_packer.sv
// Directed bench for upload_frame_packer with a 4-byte buffer so the
// overflow split is reachable; frames are compared against hand-built byte lists.
module tb_upload_frame_packer;
  import upload_pkg::*;

  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          upload_req;
  logic [7:0]    upload_data;
  logic [7:0]    upload_source;
  logic          upload_valid;
  logic          upload_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          drop_pulse;
  upload_state_e state_dbg;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] pay[16];
  int         drops;
  int         tx_valid_cycles;
  int         ready_in_tx;
  logic       rdy_seen;
  logic       stall_prev;
  logic [7:0] stall_data;
  bit         toggle_ready;

  always #5 clk = ~clk;

  upload_frame_packer #(.BUF_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .upload_req    (upload_req),
    .upload_data   (upload_data),
    .upload_source (upload_source),
    .upload_valid  (upload_valid),
    .upload_ready  (upload_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .drop_pulse    (drop_pulse),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after posedge; outputs are sampled at the following negedge.
  task automatic cycle();
    if (toggle_ready) tx_ready = ~tx_ready;
    @(negedge clk);
    if (stall_prev) begin
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'(stall_data));
    end
    if (tx_valid) tx_valid_cycles++;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (drop_pulse) drops++;
    if (upload_ready && !(state_dbg inside {ST_IDLE, ST_COLLECT})) ready_in_tx++;
    stall_prev = tx_valid && !tx_ready;
    stall_data = tx_data;
    rdy_seen   = upload_ready;
    @(posedge clk);
    #1;
  endtask

  // Handler model: asserts upload_valid one cycle after it sees upload_ready,
  // drops upload_req together with the last byte, and changes upload_source after byte 0.
  task automatic run_burst(input logic [7:0] src, input int n, input bit stray, input bit rst_mid);
    int idx = 0;
    int budget = 300;
    bit stray_done = 0;
    upload_req    = 1'b1;
    upload_valid  = 1'b0;
    upload_source = src;
    cycle();
    while (idx < n && budget > 0) begin
      upload_valid = rdy_seen;
      if (rdy_seen) begin
        upload_data   = pay[idx];
        upload_source = (idx == 0) ? src : ~src;
        if (idx == n - 1) upload_req = 1'b0;
        idx++;
      end
      cycle();
      budget--;
    end
    upload_valid = 1'b0;
    upload_req   = 1'b0;
    while (state_dbg != ST_IDLE && budget > 0) begin
      upload_valid = 1'b0;
      if (stray && !stray_done && state_dbg == ST_SRC) begin
        upload_valid = 1'b1;
        upload_data  = 8'h55;
        stray_done   = 1;
      end
      if (rst_mid && state_dbg == ST_PAYLOAD && got_q.size() == 6) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        break;
      end
      cycle();
      budget--;
    end
    upload_valid = 1'b0;
    check("burst_budget", 32'(budget > 0), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; upload_req = 1'b0; upload_valid = 1'b0; upload_data = 8'h00;
    upload_source = 8'h00; tx_ready = 1'b1; toggle_ready = 0;
    drops = 0; tx_valid_cycles = 0; ready_in_tx = 0; rdy_seen = 1'b0;
    stall_prev = 1'b0; stall_data = 8'h00;
    @(posedge clk); #1;
    cycle();
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_upload_ready", 32'(upload_ready), 32'd0);
    check("rst_drop", 32'(drop_pulse), 32'd0);
    rst = 1'b0;
    got_q.delete();

    // Basic frame
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_burst(SRC_SPI, 3, 0, 0);
    exp_q = '{8'hAA, 8'h44, 8'h03, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6C};
    check_frame("basic");
    check("basic_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("basic_drops", 32'(drops), 32'd0);

    // Empty burst
    tx_valid_cycles = 0;
    upload_req = 1'b1;
    repeat (5) cycle();
    upload_req = 1'b0;
    repeat (2) cycle();
    check("empty_tx_valid", 32'(tx_valid_cycles), 32'd0);
    check("empty_drops", 32'(drops), 32'd0);
    check("empty_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("empty_len", 32'(got_q.size()), 32'd0);

    // Backpressure: tx_ready toggles every cycle
    toggle_ready = 1;
    run_burst(SRC_SPI, 3, 0, 0);
    toggle_ready = 0;
    tx_ready = 1'b1;
    exp_q = '{8'hAA, 8'h44, 8'h03, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6C};
    check_frame("bp");

    // Overflow split into a full frame and a continuation frame
    for (int i = 0; i < 6; i++) pay[i] = 8'(i + 1);
    ready_in_tx = 0;
    drops = 0;
    run_burst(SRC_SPI, 6, 0, 0);
    exp_q = '{8'hAA, 8'h44, 8'h03, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11,
              8'hAA, 8'h44, 8'h03, 8'h00, 8'h02, 8'h05, 8'h06, 8'h10};
    check_frame("split");
    check("split_ready_in_tx", 32'(ready_in_tx), 32'd0);
    check("split_drops", 32'(drops), 32'd0);

    // Stray byte during SRC
    pay[0] = 8'hA0; pay[1] = 8'hB1;
    drops = 0;
    run_burst(SRC_UART, 2, 1, 0);
    exp_q = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h02, 8'hA0, 8'hB1, 8'h54};
    check_frame("stray");
    check("stray_drops", 32'(drops), 32'd1);

    // Reset mid-PAYLOAD, then a fresh 1-byte burst
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_burst(SRC_SPI, 3, 0, 1);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_upload_ready", 32'(upload_ready), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    got_q.delete();
    pay[0] = 8'h7E;
    run_burst(SRC_SPI, 1, 0, 0);
    exp_q = '{8'hAA, 8'h44, 8'h03, 8'h00, 8'h01, 8'h7E, 8'h82};
    check_frame("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
